// File: rtl/rand_cell_picker.sv
// rand_cell_picker: draws PICK_COUNT distinct board cells out of NUM_CELLS using values
// from an external 5-bit LFSR. Each draw pulses rand_en once and inspects the advanced
// value one cycle later; out-of-range or already-used values are re-drawn.
//
// Optional build feature, macro PICK_TIMEOUT_EN: adds an 8-bit reject counter and a
// 'timeout' output that ends a request early after 255 consecutive rejects.
module rand_cell_picker #(
    parameter int unsigned NUM_CELLS  = 16,
    parameter int unsigned PICK_COUNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] rand_num,
    output logic       rand_en,
    output logic [4:0] cell_idx,
    output logic       cell_valid,
    output logic       busy,
    output logic       done
`ifdef PICK_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StDraw,
        StCheck,
        StEmit,
        StDone
    } state_e;

    localparam logic [4:0] NumCellsW  = 5'(NUM_CELLS);
    localparam logic [4:0] PickCountW = 5'(PICK_COUNT);

    state_e                 state_q, state_d;
    logic [NUM_CELLS-1:0]   used_q, used_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [4:0]             idx_q, idx_d;

`ifdef PICK_TIMEOUT_EN
    logic [7:0]             rej_q, rej_d;
    logic                   tmo_q, tmo_d;
`endif

    logic [4:0]             rn_m1;
    logic                   rn_in_range;
    logic [NUM_CELLS-1:0]   rn_onehot;
    logic [NUM_CELLS-1:0]   idx_onehot;
    logic                   rn_used;
    logic                   accept;
    logic [4:0]             cnt_inc;

    // Decode the candidate cell and the latched cell into one-hot masks over the board.
    always_comb begin
        rn_onehot  = '0;
        idx_onehot = '0;
        for (int i = 0; i < int'(NUM_CELLS); i++) begin
            if (rn_m1 == 5'(i)) begin
                rn_onehot[i] = 1'b1;
            end
            if (idx_q == 5'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign rn_m1       = rand_num - 5'd1;
    assign rn_in_range = (rand_num != 5'd0) && (rand_num <= NumCellsW);
    assign rn_used     = |(used_q & rn_onehot);
    assign accept      = rn_in_range && !rn_used;
    assign cnt_inc     = cnt_q + 5'd1;

    // Next-state logic for the draw FSM and its bookkeeping registers.
    always_comb begin
        state_d = state_q;
        used_d  = used_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef PICK_TIMEOUT_EN
        rej_d   = rej_q;
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDraw;
                    used_d  = '0;
                    cnt_d   = '0;
`ifdef PICK_TIMEOUT_EN
                    rej_d   = '0;
`endif
                end
            end
            StDraw: begin
                state_d = StCheck;
            end
            StCheck: begin
                if (accept) begin
                    // cell_idx only ever changes here, so rejected values never appear on it.
                    idx_d   = rn_m1;
                    state_d = StEmit;
`ifdef PICK_TIMEOUT_EN
                    rej_d   = '0;
`endif
                end else begin
                    state_d = StDraw;
`ifdef PICK_TIMEOUT_EN
                    rej_d   = rej_q + 8'd1;
                    if (rej_q == 8'd254) begin
                        state_d = StDone;
                        tmo_d   = 1'b1;
                    end
`endif
                end
            end
            StEmit: begin
                used_d  = used_q | idx_onehot;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == PickCountW) ? StDone : StDraw;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and bookkeeping registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            used_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

`ifdef PICK_TIMEOUT_EN
    // Reject counter and timeout flag; the flag is high exactly during the DONE cycle it causes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            rej_q <= rej_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`endif

    // Strobes are decoded from state alone so reset clears them without waiting for a clock.
    assign rand_en    = (state_q == StDraw);
    assign cell_valid = (state_q == StEmit);
    assign done       = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign cell_idx   = idx_q;

endmodule

// File: tb/tb_rand_cell_picker.sv
// tb_rand_cell_picker: directed, table-driven bench for rand_cell_picker.
// A 4-pick instance is fed scripted rand_num values; a 16-pick instance is fed a real
// 5-bit LFSR. Define PICK_TIMEOUT_EN to also exercise the timeout path.
module tb_rand_cell_picker;

    typedef struct {
        logic [4:0] rn;
        logic       acc;
        logic [4:0] idx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] rand_num = 5'd1;
    logic       rand_en;
    logic [4:0] cell_idx;
    logic       cell_valid;
    logic       busy;
    logic       done;

    logic       start16;
    logic [4:0] rand16 = 5'd1;
    logic       rand_en16;
    logic [4:0] cell_idx16;
    logic       cell_valid16;
    logic       busy16;
    logic       done16;

`ifdef PICK_TIMEOUT_EN
    logic       timeout;
    logic       timeout16;
    int         tmo_cnt;
    int         tmo_cyc;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    // scripted source and monitor state
    logic [4:0] seq [16];
    int         seq_len = 0;
    logic       clr = 1'b0;
    int         sp, cyc = 0, got_n, en_cnt, done_cnt, done_cyc, start_cyc, gap, hold_bad;
    int         got_idx [16];
    int         got_cyc [16];
    logic [4:0] last_idx = 5'd0;
    logic       in_req = 1'b0;

    logic        clr16 = 1'b0;
    int          v16, d16, bad16;
    logic [15:0] seen16;

    vec_t tbl [11];

    always #5 clk = ~clk;

    rand_cell_picker #(.NUM_CELLS(16), .PICK_COUNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rand_num  (rand_num),
        .rand_en   (rand_en),
        .cell_idx  (cell_idx),
        .cell_valid(cell_valid),
        .busy      (busy),
        .done      (done)
`ifdef PICK_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    rand_cell_picker #(.NUM_CELLS(16), .PICK_COUNT(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .start     (start16),
        .rand_num  (rand16),
        .rand_en   (rand_en16),
        .cell_idx  (cell_idx16),
        .cell_valid(cell_valid16),
        .busy      (busy16),
        .done      (done16)
`ifdef PICK_TIMEOUT_EN
        ,
        .timeout   (timeout16)
`endif
    );

    // Upstream source model and observer for the 4-pick instance.
    always @(negedge clk) begin
        cyc++;
        if (clr) begin
            sp = 0; got_n = 0; en_cnt = 0; done_cnt = 0; done_cyc = 0; start_cyc = 0;
            gap = 0; hold_bad = 0; in_req = 1'b0;
`ifdef PICK_TIMEOUT_EN
            tmo_cnt = 0; tmo_cyc = 0;
`endif
        end else if (rst) begin
            in_req   = 1'b0;
            last_idx = 5'd0;
        end else begin
            if (in_req && !busy) gap++;
            if (rand_en) begin
                en_cnt++;
                rand_num = (sp < seq_len) ? seq[sp] : 5'd31;
                sp++;
            end
            if (cell_valid) begin
                if (got_n < 16) begin
                    got_idx[got_n] = int'(cell_idx);
                    got_cyc[got_n] = cyc;
                end
                got_n++;
                last_idx = cell_idx;
            end else if (cell_idx != last_idx) begin
                hold_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                in_req   = 1'b0;
            end
`ifdef PICK_TIMEOUT_EN
            if (timeout) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
`endif
            if (start && !busy) begin
                in_req    = 1'b1;
                start_cyc = cyc;
            end
        end
    end

    // Real LFSR (x^5 + x^3 + 1) and observer for the 16-pick instance.
    always @(negedge clk) begin
        if (clr16) begin
            v16 = 0; d16 = 0; bad16 = 0; seen16 = '0;
        end else begin
            if (rand_en16) rand16 = {rand16[3:0], rand16[4] ^ rand16[2]};
            if (cell_valid16) begin
                if (cell_idx16 > 5'd15 || seen16[cell_idx16[3:0]]) bad16++;
                seen16[cell_idx16[3:0]] = 1'b1;
                v16++;
            end
            if (done16) d16++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic load(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) seq[i - lo] = tbl[i].rn;
        seq_len = hi - lo + 1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (done_cnt == 0 && i < limit) begin
            tick();
            i++;
        end
        if (done_cnt == 0) check("done_wait", 0, 1);
        tick();
    endtask

    // Compare one finished request against table rows lo..hi.
    task automatic compare_req(input string tag, input int lo, input int hi);
        int k;
        int lat;
        k   = 0;
        lat = 3;
        for (int i = lo; i <= hi; i++) begin
            if (tbl[i].acc) begin
                check({tag, "_idx"}, (k < 16) ? got_idx[k] : -1, int'(tbl[i].idx));
                k++;
            end else if (k == 0) begin
                lat += 2;
            end
        end
        check({tag, "_n_valid"}, got_n, k);
        check({tag, "_n_rand_en"}, en_cnt, hi - lo + 1);
        check({tag, "_n_done"}, done_cnt, 1);
        check({tag, "_first_latency"}, got_cyc[0] - start_cyc, lat);
        check({tag, "_done_after_last"}, done_cyc - got_cyc[k - 1], 1);
        check({tag, "_idx_hold"}, hold_bad, 0);
        check({tag, "_busy_gap"}, gap, 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        // A: all accepted; B: mixture of rejects (out of range, duplicate, 31)
        tbl[0]  = '{5'd3,  1'b1, 5'd2};
        tbl[1]  = '{5'd7,  1'b1, 5'd6};
        tbl[2]  = '{5'd1,  1'b1, 5'd0};
        tbl[3]  = '{5'd16, 1'b1, 5'd15};
        tbl[4]  = '{5'd20, 1'b0, 5'd0};
        tbl[5]  = '{5'd3,  1'b1, 5'd2};
        tbl[6]  = '{5'd3,  1'b0, 5'd0};
        tbl[7]  = '{5'd31, 1'b0, 5'd0};
        tbl[8]  = '{5'd5,  1'b1, 5'd4};
        tbl[9]  = '{5'd9,  1'b1, 5'd8};
        tbl[10] = '{5'd12, 1'b1, 5'd11};

        rst = 1'b1; start = 1'b0; start16 = 1'b0;
        clr = 1'b1; clr16 = 1'b1;
        tick(); tick();
        clr = 1'b0; clr16 = 1'b0;
        check("rst_rand_en", int'(rand_en), 0);
        check("rst_cell_valid", int'(cell_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cell_idx", int'(cell_idx), 0);
        rst = 1'b0;
        tick();

        // A: straight sequence
        load(0, 3);
        pulse_start();
        wait_done(200);
        compare_req("seqA", 0, 3);

        // B: rejects interleaved
        load(4, 10);
        pulse_start();
        wait_done(200);
        compare_req("seqB", 4, 10);

        // C: start pulsed during EMIT of the 2nd cell must be ignored
        load(0, 3);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (cell_valid && got_n == 1) break;
            tick();
        end
        check("ign_in_emit2", int'(cell_valid && got_n == 1), 1);
        pulse_start();
        wait_done(200);
        repeat (8) tick();
        check("ign_n_valid", got_n, 4);
        check("ign_n_done", done_cnt, 1);
        check("ign_n_rand_en", en_cnt, 4);
        check("ign_busy_after", int'(busy), 0);

        // D: asynchronous reset in CHECK after two accepts, then a fresh request
        load(0, 3);
        pulse_start();
        for (int i = 0; i < 50 && got_n < 2; i++) tick();
        for (int i = 0; i < 10 && !rand_en; i++) tick();
        tick();
        check("rst_mid_in_check", int'(!rand_en && busy && !cell_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_rand_en", int'(rand_en), 0);
        check("rstmid_cell_valid", int'(cell_valid), 0);
        check("rstmid_done", int'(done), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_cell_idx", int'(cell_idx), 0);
        #10 rst = 1'b0;
        tick();
        check("rstmid_no_done", done_cnt, 0);
        load(0, 3);
        pulse_start();
        wait_done(200);
        compare_req("after_rst", 0, 3);

        // E: 16 picks with a real LFSR
        pulse16();

`ifdef PICK_TIMEOUT_EN
        // F: rand_num stuck at 31 ends the request by timeout
        seq_len = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulse_start();
        wait_done(700);
        check("tmo_n_timeout", tmo_cnt, 1);
        check("tmo_n_done", done_cnt, 1);
        check("tmo_with_done", tmo_cyc, done_cyc);
        check("tmo_n_valid", got_n, 0);
        check("tmo_n_rand_en", en_cnt, 255);
        check("tmo_busy_after", int'(busy), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    task automatic pulse16();
        int i;
        start16 = 1'b1;
        tick();
        start16 = 1'b0;
        i = 0;
        while (d16 == 0 && i < 2000) begin
            tick();
            i++;
        end
        tick();
        check("lfsr16_n_valid", v16, 16);
        check("lfsr16_all_cells", int'(seen16), 32'hFFFF);
        check("lfsr16_bad", bad16, 0);
        check("lfsr16_n_done", d16, 1);
        check("lfsr16_busy_after", int'(busy16), 0);
    endtask

endmodule

// File: doc/rand_cell_picker.md
RAND_CELL_PICKER -- requirements
Module: rand_cell_picker

Interface
REQ-001 Parameter NUM_CELLS, default 16: number of selectable board cells, legal range 1..31.
REQ-002 Parameter PICK_COUNT, default 8: distinct cells drawn per request, legal range 1..NUM_CELLS.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request a new draw of PICK_COUNT distinct cells; sampled only in IDLE.
REQ-006 rand_num  input  5  current value of the upstream 5-bit LFSR (nonzero, 1..31).
REQ-007 rand_en  output  1  advance request to the upstream LFSR enable input.
REQ-008 cell_idx  output  5  accepted cell index, 0..NUM_CELLS-1, valid while cell_valid=1.
REQ-009 cell_valid  output  1  one-cycle strobe per accepted cell.
REQ-010 busy  output  1  high from the cycle after start acceptance until DONE is left.
REQ-011 done  output  1  one-cycle strobe after the last cell is emitted.

Function
REQ-012 FSM states: IDLE, DRAW, CHECK, EMIT, DONE; all outputs registered or decoded from state only.
REQ-013 IDLE: start=1 -> DRAW next cycle; same edge clears used[NUM_CELLS-1:0] and pick counter cnt to 0.
REQ-014 DRAW: rand_en=1 for exactly this cycle; unconditional -> CHECK.
REQ-015 CHECK: rand_en=0; sample rand_num (value already advanced by the DRAW-cycle enable).
REQ-016 CHECK accept rule: rand_num in 1..NUM_CELLS and used[rand_num-1]=0 -> latch cell_idx=rand_num-1, -> EMIT.
REQ-017 CHECK reject rule: rand_num=0, rand_num>NUM_CELLS, or cell already used -> DRAW (re-draw), cnt unchanged.
REQ-018 EMIT: cell_valid=1 for this cycle; set used[cell_idx]; cnt+1; if cnt+1=PICK_COUNT -> DONE, else -> DRAW.
REQ-019 DONE: done=1 for this cycle; -> IDLE; busy=1 in DRAW, CHECK, EMIT, DONE, 0 in IDLE.
REQ-020 Minimum latency start to first cell_valid: 3 cycles (DRAW, CHECK, EMIT); each reject adds 2 cycles.
REQ-021 start while not IDLE is ignored; no queuing, no restart.
REQ-022 cell_idx holds last accepted value between strobes; never shows a rejected value.
REQ-023 No cell index emitted twice within one request; indices are width-extended to 5 bits, no wrap.

Reset
REQ-024 rst=1 forces IDLE immediately, regardless of clock.
REQ-025 Reset values: rand_en=0, cell_valid=0, done=0, busy=0, cell_idx=0, cnt=0, used=all 0.
REQ-026 Reset mid-request abandons the draw; no done strobe; next start begins a fresh request.

Configuration
REQ-027 Macro PICK_TIMEOUT_EN: when defined, an 8-bit reject counter clears on every accept and on start acceptance, and increments on every reject.
REQ-028 With PICK_TIMEOUT_EN: output timeout (1 bit, reset 0) pulses 1 cycle and FSM -> DONE when the reject counter reaches 255; done also pulses.
REQ-029 Without PICK_TIMEOUT_EN: no timeout port, no reject counter; draws repeat until PICK_COUNT cells are accepted.

Verification
REQ-030 Bench drives rand_num directly; NUM_CELLS=16, PICK_COUNT=4; rand_num sequence 3,7,1,16 after each DRAW -> cell_idx 2,6,0,15, cell_valid 4 strobes, done 1 cycle after the 4th strobe.
REQ-031 Rejects: sequence 20,3,3,31,5,9,12 -> accepted 2,4,8,11 only; rand_en pulse count 7; busy high throughout.
REQ-032 start pulsed during EMIT of 2nd cell -> no effect; exactly 4 cell_valid and 1 done.
REQ-033 rst asserted asynchronously in CHECK after 2 accepts -> all outputs zero same cycle; new start yields full 4-cell sequence, previously used cells accepted again.
REQ-034 With real LFSR attached, NUM_CELLS=16, PICK_COUNT=16 -> 16 distinct indices 0..15, then done.
REQ-035 PICK_TIMEOUT_EN defined, rand_num held at 31 -> timeout and done pulse after 255 rejects, busy drops, cell_valid never asserted.
